// File: rtl/conv_8_32_arb_pkg.sv
// Shared definitions for the two-requester 8->32 byte packer front end.
package conv_8_32_arb_pkg;

    // Datapath geometry
    localparam int LANES    = 4;
    localparam int BYTE_W   = 8;
    localparam int WORD_W   = LANES * BYTE_W;
    localparam int CNT_W    = 2;

    // Requester identification
    localparam int NUM_REQ  = 2;
    localparam int REQ_ID_W = 1;

    typedef logic [REQ_ID_W-1:0] req_id_t;

    // Controller states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PACK = 2'd1,
        ST_EMIT = 2'd2
    } state_t;

    // One-hot ready pattern for a given requester id
    function automatic logic [NUM_REQ-1:0] req_onehot(input req_id_t id);
        req_onehot = NUM_REQ'(1) << id;
    endfunction

endpackage

// File: rtl/conv_8_32_arb_rr_arb2.sv
// Two-way round-robin arbiter: a tie is resolved by the pointer,
// a single active request wins outright.
module rr_arb2
    import conv_8_32_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] i_req,
    input  req_id_t            i_ptr,
    output logic               o_any,
    output req_id_t            o_grant
);

    // Pick the winner: pointer on a tie, otherwise whichever is requesting
    always_comb begin
        o_grant = '0;
        if (&i_req) begin
            o_grant = i_ptr;
        end else if (i_req[1]) begin
            o_grant = req_id_t'(1);
        end
    end

    assign o_any = |i_req;

endmodule

// File: rtl/conv_8_32_arb.sv
// Two-requester byte-to-word packer. Grants one 8-bit stream at a time,
// fills lanes 0..3 in arrival order and presents registered 32-bit words
// with byte enables, last flag and source id.
module conv_8_32_arb
    import conv_8_32_arb_pkg::*;
#(
    parameter bit LOCK_PKT = 1'b1
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic              in0_valid,
    input  logic [BYTE_W-1:0] in0_data,
    input  logic              in0_last,
    output logic              in0_ready,
    input  logic              in1_valid,
    input  logic [BYTE_W-1:0] in1_data,
    input  logic              in1_last,
    output logic              in1_ready,
    output logic              out_valid,
    output logic [WORD_W-1:0] out_data,
    output logic [LANES-1:0]  out_be,
    output logic              out_last,
    output logic              out_src,
    input  logic              out_ready
);

    // Controller registers
    state_t             r_state;
    req_id_t            r_grant;
    req_id_t            r_rr_ptr;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_last;
    logic               r_out_valid;
    logic [NUM_REQ-1:0] r_in_ready;

    // Combinational helpers
    logic [NUM_REQ-1:0] w_req;
    logic               w_arb_any;
    req_id_t            w_arb_grant;
    logic               w_sel_valid;
    logic [BYTE_W-1:0]  w_sel_data;
    logic               w_sel_last;
    logic               w_accept;
    logic               w_word_done;
    logic               w_emit_xfer;
    logic [WORD_W-1:0]  w_data;
    logic [LANES-1:0]   w_be;

    assign w_req = {in1_valid, in0_valid};

    rr_arb2 u_arb (
        .i_req   (w_req),
        .i_ptr   (r_rr_ptr),
        .o_any   (w_arb_any),
        .o_grant (w_arb_grant)
    );

    // Only the granted stream reaches the lane writers; the other is ignored
    assign w_sel_valid = r_grant[0] ? in1_valid : in0_valid;
    assign w_sel_data  = r_grant[0] ? in1_data  : in0_data;
    assign w_sel_last  = r_grant[0] ? in1_last  : in0_last;

    // Data and last are only looked at when a byte is really accepted, so
    // garbage on an idle input cannot leak into the word.
    assign w_accept    = (r_state == ST_PACK) && r_in_ready[r_grant] && w_sel_valid;
    assign w_word_done = w_accept && ((r_cnt == CNT_W'(LANES - 1)) || w_sel_last);
    assign w_emit_xfer = r_out_valid && out_ready;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [BYTE_W-1:0] r_byte;
            logic              r_en;

            // Load this lane when the lane counter points at it; wipe after the word leaves
            always_ff @(posedge clk or negedge reset_L) begin
                if (!reset_L) begin
                    r_byte <= '0;
                    r_en   <= 1'b0;
                end else if (w_emit_xfer) begin
                    r_byte <= '0;
                    r_en   <= 1'b0;
                end else if (w_accept && (r_cnt == CNT_W'(gi))) begin
                    r_byte <= w_sel_data;
                    r_en   <= 1'b1;
                end
            end

            assign w_data[gi*BYTE_W +: BYTE_W] = r_byte;
            assign w_be[gi]                    = r_en;
        end
    endgenerate

    // Arbitration, lane sequencing and word hand-off
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_state     <= ST_IDLE;
            r_grant     <= '0;
            r_rr_ptr    <= '0;
            r_cnt       <= '0;
            r_last      <= 1'b0;
            r_out_valid <= 1'b0;
            r_in_ready  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_arb_any) begin
                        r_grant    <= w_arb_grant;
                        r_in_ready <= req_onehot(w_arb_grant);
                        r_state    <= ST_PACK;
                    end
                end
                ST_PACK: begin
                    if (w_accept) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                    if (w_word_done) begin
                        r_last      <= w_sel_last;
                        r_out_valid <= 1'b1;
                        r_in_ready  <= '0;
                        r_state     <= ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    if (w_emit_xfer) begin
                        r_out_valid <= 1'b0;
                        r_last      <= 1'b0;
                        r_cnt       <= '0;
                        if (r_last || !LOCK_PKT) begin
                            // Hand preference to the other requester; switching only happens via IDLE
                            r_rr_ptr <= ~r_grant;
                            r_state  <= ST_IDLE;
                        end else begin
                            r_in_ready <= req_onehot(r_grant);
                            r_state    <= ST_PACK;
                        end
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_in_ready <= '0;
                end
            endcase
        end
    end

    assign in0_ready = r_in_ready[0];
    assign in1_ready = r_in_ready[1];
    assign out_valid = r_out_valid;
    assign out_data  = w_data;
    assign out_be    = w_be;
    assign out_last  = r_last;
    assign out_src   = r_grant[0];

endmodule

// File: tb/tb_conv_8_32_arb.sv
// Bench for conv_8_32_arb: a locked-packet instance and a per-word
// re-arbitrating instance, driven by queue-backed byte sources and checked
// against per-requester expected word queues built from the byte streams.
module tb_conv_8_32_arb;

    logic            clk = 1'b0;
    logic            reset_L;
    logic [3:0]      v, lst, rdy;          // index = dut*2 + requester
    logic [3:0][7:0] dat;
    logic [1:0]      ov, ol, os, ordy;     // index = dut
    logic [1:0][31:0] od;
    logic [1:0][3:0]  obe;

    always #5 clk = ~clk;

    conv_8_32_arb #(.LOCK_PKT(1'b1)) u_lock (
        .clk(clk), .reset_L(reset_L),
        .in0_valid(v[0]), .in0_data(dat[0]), .in0_last(lst[0]), .in0_ready(rdy[0]),
        .in1_valid(v[1]), .in1_data(dat[1]), .in1_last(lst[1]), .in1_ready(rdy[1]),
        .out_valid(ov[0]), .out_data(od[0]), .out_be(obe[0]), .out_last(ol[0]),
        .out_src(os[0]), .out_ready(ordy[0])
    );

    conv_8_32_arb #(.LOCK_PKT(1'b0)) u_free (
        .clk(clk), .reset_L(reset_L),
        .in0_valid(v[2]), .in0_data(dat[2]), .in0_last(lst[2]), .in0_ready(rdy[2]),
        .in1_valid(v[3]), .in1_data(dat[3]), .in1_last(lst[3]), .in1_ready(rdy[3]),
        .out_valid(ov[1]), .out_data(od[1]), .out_be(obe[1]), .out_last(ol[1]),
        .out_src(os[1]), .out_ready(ordy[1])
    );

    typedef struct { logic [7:0] data; logic last; } byte_t;
    typedef struct { logic [31:0] data; logic [3:0] be; logic last; } word_t;
    typedef struct { logic src; logic [31:0] data; logic [3:0] be; logic last; } obs_t;
    typedef struct { int req; int n; logic [31:0] bytes; logic [31:0] exp_data; logic [3:0] exp_be; } vec_t;

    byte_t       srcq[4][$];
    word_t       expq[4][$];
    obs_t        obsq[2][$];
    logic [31:0] acc_d[4];
    int          acc_n[4];
    int          tests = 0, fails = 0, cyc = 0;
    bit          gate_rand = 0, ordy_rand = 0;
    bit [1:0]    ordy_force = 2'b11;
    bit          take[4];
    int          take_cnt[4];
    int          last_take_cyc[4];
    bit          ov_prev[2];
    int          rise_cyc[2];
    bit          have_prev = 0;
    logic        prev_last, prev_src;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Queue a byte for a source and extend that source's expected word stream
    task automatic push_byte(input int k, input logic [7:0] b, input logic l);
        byte_t e;
        word_t w;
        e.data = b;
        e.last = l;
        srcq[k].push_back(e);
        acc_d[k][acc_n[k]*8 +: 8] = b;
        acc_n[k]++;
        if (acc_n[k] == 4 || l) begin
            w.data = acc_d[k];
            w.be   = 4'((1 << acc_n[k]) - 1);
            w.last = l;
            expq[k].push_back(w);
            acc_d[k] = '0;
            acc_n[k] = 0;
        end
    endtask

    task automatic push_pkt(input int k, input int n, input logic [31:0] bytes, input bit rnd);
        logic [7:0] b;
        for (int i = 0; i < n; i++) begin
            b = rnd ? 8'($urandom) : bytes[(i%4)*8 +: 8];
            push_byte(k, b, i == n - 1);
        end
    endtask

    task automatic clear_model();
        for (int k = 0; k < 4; k++) begin
            srcq[k].delete();
            expq[k].delete();
            acc_d[k] = '0;
            acc_n[k] = 0;
            take[k]  = 0;
        end
        obsq[0].delete();
        obsq[1].delete();
        have_prev = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_L = 1'b0;
        clear_model();
        repeat (2) @(negedge clk);
        reset_L = 1'b1;
    endtask

    task automatic wait_word(input int d, output obs_t o, output bit ok);
        int t;
        t = 0;
        while (obsq[d].size() == 0 && t < 300) begin
            @(negedge clk);
            #2;
            t++;
        end
        if (obsq[d].size() == 0) begin
            tests++;
            fails++;
            $display("FAIL word_timeout dut%0d: got no word, expected one within 300 cycles", d);
            ok = 0;
            o  = '{default: '0};
        end else begin
            o  = obsq[d].pop_front();
            ok = 1;
        end
    endtask

    task automatic score(input int d);
        obs_t  o;
        word_t w;
        int    k;
        o.src  = os[d];
        o.data = od[d];
        o.be   = obe[d];
        o.last = ol[d];
        obsq[d].push_back(o);
        k = d*2 + int'(os[d]);
        tests++;
        if (expq[k].size() == 0) begin
            fails++;
            $display("FAIL word_unexpected dut%0d src%0d: got %h be %h, expected no word", d, o.src, o.data, o.be);
        end else begin
            w = expq[k].pop_front();
            if (o.data !== w.data || o.be !== w.be || o.last !== w.last) begin
                fails++;
                $display("FAIL word dut%0d src%0d: got %h be %h last %b, expected %h be %h last %b",
                         d, o.src, o.data, o.be, o.last, w.data, w.be, w.last);
            end
        end
        if (d == 0) begin
            if (have_prev && !prev_last) begin
                tests++;
                if (o.src !== prev_src) begin
                    fails++;
                    $display("FAIL lock_hold: got src %0d, expected src %0d mid-packet", o.src, prev_src);
                end
            end
            have_prev = 1;
            prev_last = o.last;
            prev_src  = o.src;
        end
    endtask

    // Byte sources and consumer ready, updated just after each rising edge
    initial begin
        bit keep;
        v = '0; lst = '0; dat = '0; ordy = '0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            for (int k = 0; k < 4; k++) begin
                keep = v[k] && !take[k];
                if (take[k]) begin
                    if (srcq[k].size() > 0) void'(srcq[k].pop_front());
                    take[k] = 0;
                end
                if (srcq[k].size() == 0) v[k] = 1'b0;
                else if (!keep) v[k] = !gate_rand || ($urandom_range(0, 2) != 0);
                if (v[k]) begin
                    dat[k] = srcq[k][0].data;
                    lst[k] = srcq[k][0].last;
                end else begin
                    dat[k] = 8'($urandom);
                    lst[k] = 1'($urandom);
                end
            end
            for (int d = 0; d < 2; d++)
                ordy[d] = ordy_rand ? ($urandom_range(0, 3) != 0) : ordy_force[d];
        end
    end

    // Handshake monitor, sampled mid-cycle
    initial forever begin
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            if (v[k] && rdy[k]) begin
                take[k] = 1;
                take_cnt[k]++;
                last_take_cyc[k] = cyc;
            end
        end
        for (int d = 0; d < 2; d++) begin
            if (ov[d] && !ov_prev[d]) rise_cyc[d] = cyc;
            ov_prev[d] = ov[d];
            if (ov[d] && ordy[d]) score(d);
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: got no finish, expected end within 80000 cycles");
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[4];
        obs_t o;
        bit   ok;
        int   e_src[4];
        int   e_last[4];
        int   t, base, remaining;

        vt[0] = '{0, 4, 32'h44332211, 32'h44332211, 4'hF};
        vt[1] = '{1, 2, 32'h1234BBAA, 32'h0000BBAA, 4'h3};
        vt[2] = '{0, 1, 32'hFFFFFF5A, 32'h0000005A, 4'h1};
        vt[3] = '{1, 3, 32'h77CCDDEE, 32'h00CCDDEE, 4'h7};

        // Reset state
        reset_L = 1'b1;
        #1 reset_L = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_out_valid", ov, 0);
        check("rst_out_data", od, 0);
        check("rst_out_be", obe, 0);
        check("rst_out_last", ol, 0);
        check("rst_out_src", os, 0);
        check("rst_in_ready", rdy, 0);
        reset_L = 1'b1;

        // Single packets, table-driven
        for (int i = 0; i < 4; i++) begin
            push_pkt(vt[i].req, vt[i].n, vt[i].bytes, 0);
            wait_word(0, o, ok);
            if (ok) begin
                check($sformatf("vec%0d_data", i), o.data, vt[i].exp_data);
                check($sformatf("vec%0d_be", i), o.be, vt[i].exp_be);
                check($sformatf("vec%0d_last", i), o.last, 1);
                check($sformatf("vec%0d_src", i), o.src, vt[i].req);
                if (i == 0) check("latency", rise_cyc[0] - last_take_cyc[0], 1);
            end
            repeat (2) @(negedge clk);
        end

        // Tie from reset: req0 first, then alternating
        do_reset();
        push_pkt(0, 4, 32'h03020100, 0);
        push_pkt(1, 4, 32'h13121110, 0);
        push_pkt(0, 4, 32'h23222120, 0);
        push_pkt(1, 4, 32'h33323130, 0);
        e_src = '{0, 1, 0, 1};
        for (int i = 0; i < 4; i++) begin
            wait_word(0, o, ok);
            if (ok) check($sformatf("tie_src%0d", i), o.src, e_src[i]);
        end

        // Packet lock versus per-word re-arbitration
        do_reset();
        push_pkt(0, 8, 32'h0, 1);
        push_pkt(1, 4, 32'h0, 1);
        push_pkt(2, 8, 32'h0, 1);
        push_pkt(3, 8, 32'h0, 1);
        e_src  = '{0, 0, 1, 0};
        e_last = '{0, 1, 1, 0};
        for (int i = 0; i < 3; i++) begin
            wait_word(0, o, ok);
            if (ok) begin
                check($sformatf("lock_src%0d", i), o.src, e_src[i]);
                check($sformatf("lock_last%0d", i), o.last, e_last[i]);
            end
        end
        e_src  = '{0, 1, 0, 1};
        e_last = '{0, 0, 1, 1};
        for (int i = 0; i < 4; i++) begin
            wait_word(1, o, ok);
            if (ok) begin
                check($sformatf("free_src%0d", i), o.src, e_src[i]);
                check($sformatf("free_last%0d", i), o.last, e_last[i]);
            end
        end

        // Consumer stall for five cycles in EMIT
        do_reset();
        ordy_force[0] = 1'b0;
        push_pkt(0, 4, 32'h04030201, 0);
        push_pkt(1, 4, 32'h0D0C0B0A, 0);
        t = 0;
        while (!ov[0] && t < 50) begin
            @(negedge clk);
            #2;
            t++;
        end
        for (int i = 0; i < 5; i++) begin
            check($sformatf("stall%0d_valid", i), ov[0], 1);
            check($sformatf("stall%0d_data", i), od[0], 32'h04030201);
            check($sformatf("stall%0d_be", i), obe[0], 4'hF);
            check($sformatf("stall%0d_src", i), os[0], 0);
            check($sformatf("stall%0d_in_ready", i), rdy[1:0], 0);
            if (i < 4) begin
                @(negedge clk);
                #2;
            end
        end
        ordy_force[0] = 1'b1;
        @(negedge clk);
        #2;
        check("stall_hold_valid", ov[0], 1);
        @(negedge clk);
        #2;
        check("stall_xfer_valid", ov[0], 0);
        check("stall_xfer_words", obsq[0].size(), 1);
        wait_word(0, o, ok);
        if (ok) check("stall_word0", o.data, 32'h04030201);
        wait_word(0, o, ok);
        if (ok) begin
            check("stall_word1", o.data, 32'h0D0C0B0A);
            check("stall_word1_src", o.src, 1);
        end

        // Reset in the middle of a word
        do_reset();
        base = take_cnt[0];
        push_pkt(0, 4, 32'hA4A3A2A1, 0);
        t = 0;
        while (take_cnt[0] < base + 2 && t < 50) begin
            @(negedge clk);
            #2;
            t++;
        end
        check("midrst_bytes_seen", take_cnt[0] - base, 2);
        @(posedge clk);
        #3 reset_L = 1'b0;
        #1;
        check("midrst_out_valid", ov, 0);
        check("midrst_out_data", od, 0);
        check("midrst_out_be", obe, 0);
        check("midrst_out_last", ol, 0);
        check("midrst_out_src", os, 0);
        check("midrst_in_ready", rdy, 0);
        clear_model();
        repeat (2) @(negedge clk);
        reset_L = 1'b1;
        push_pkt(1, 4, 32'hB4B3B2B1, 0);
        wait_word(0, o, ok);
        if (ok) begin
            check("postrst_data", o.data, 32'hB4B3B2B1);
            check("postrst_be", o.be, 4'hF);
            check("postrst_src", o.src, 1);
            check("postrst_last", o.last, 1);
        end

        // Random traffic with gaps and back-pressure on both instances
        do_reset();
        gate_rand = 1;
        ordy_rand = 1;
        for (int k = 0; k < 4; k++)
            for (int p = 0; p < 12; p++)
                push_pkt(k, $urandom_range(1, 9), 32'h0, 1);
        t = 0;
        remaining = 1;
        while (remaining != 0 && t < 30000) begin
            @(negedge clk);
            #2;
            t++;
            remaining = 0;
            for (int k = 0; k < 4; k++) remaining += srcq[k].size() + expq[k].size();
        end
        check("rand_drain", remaining, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
